// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache SRAM arbiter.
package dcache_pkg;

  localparam int unsigned ADDR_WIDTH = 9;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

  // Requester indices within the write and read request vectors
  localparam int unsigned REQ_STORE  = 0;
  localparam int unsigned REQ_REFILL = 1;
  localparam int unsigned REQ_LOAD   = 0;
  localparam int unsigned REQ_EVICT  = 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
  } wr_req_t;

endpackage

// File: rtl/dcache_sram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer records the last transferred requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic [1:0] i_xfer,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = '0;
    if (!rst) begin
      o_grant[0] = i_req[0] & (~i_req[1] | r_last);
      o_grant[1] = i_req[1] & (~i_req[0] | ~r_last);
    end
  end

  // Only real transfers move the pointer, so a masked grant keeps its priority
  always_ff @(posedge clk) begin
    if (rst)
      r_last <= 1'b1;
    else if (i_xfer[0])
      r_last <= 1'b0;
    else if (i_xfer[1])
      r_last <= 1'b1;
  end

endmodule

// File: rtl/dcache_sram_arbiter.sv
// Shares one simple dual-port data SRAM between store/refill writers and load/evict readers.
// Optional same-cycle write-to-read forwarding: define DCACHE_ARB_BYPASS_EN.
module dcache_sram_arbiter #(
  parameter int unsigned ADDR_WIDTH = dcache_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = dcache_pkg::DATA_WIDTH,
  parameter int unsigned BE_WIDTH   = dcache_pkg::BE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w0_valid,
  output logic                  w0_ready,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  input  logic [BE_WIDTH-1:0]   w0_be,
  input  logic                  w1_valid,
  output logic                  w1_ready,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  input  logic [BE_WIDTH-1:0]   w1_be,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r0_rvalid,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  output logic [BE_WIDTH-1:0]   sram_wr_byte_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data
);

  import dcache_pkg::*;

  logic [1:0]            w_wr_grant;
  logic [1:0]            w_rd_grant_raw;
  logic [1:0]            w_rd_grant;
  wr_req_t               w_wr_win;
  logic [ADDR_WIDTH-1:0] w_rd_addr_win;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_addr_eq;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  logic                  r_rd_pend;
  logic                  r_rd_tag;
  logic [1:0]            r_rsp_vld;

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   ({w1_valid, w0_valid}),
    .i_xfer  (w_wr_grant),
    .o_grant (w_wr_grant)
  );

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   ({r1_valid, r0_valid}),
    .i_xfer  (w_rd_grant),
    .o_grant (w_rd_grant_raw)
  );

  always_comb begin
    w_wr_win = '{addr: w0_addr, data: w0_data, be: w0_be};
    if (w_wr_grant[REQ_REFILL])
      w_wr_win = '{addr: w1_addr, data: w1_data, be: w1_be};
  end

  assign w_rd_addr_win = w_rd_grant_raw[REQ_EVICT] ? r1_addr : r0_addr;
  assign w_wr_fire     = |w_wr_grant;
  assign w_addr_eq     = w_wr_fire && (w_wr_win.addr == w_rd_addr_win);

`ifdef DCACHE_ARB_BYPASS_EN
  assign w_rd_grant = w_rd_grant_raw;
`else
  // Only one raw read grant can be set, so clearing both drops just the colliding winner
  assign w_rd_grant = w_addr_eq ? 2'b00 : w_rd_grant_raw;
`endif

  assign w_rd_fire = |w_rd_grant;
  assign w0_ready  = w_wr_grant[REQ_STORE];
  assign w1_ready  = w_wr_grant[REQ_REFILL];
  assign r0_ready  = w_rd_grant[REQ_LOAD];
  assign r1_ready  = w_rd_grant[REQ_EVICT];

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_wr_en      <= 1'b0;
      sram_wr_addr    <= '0;
      sram_wr_data    <= '0;
      sram_wr_byte_en <= '0;
      sram_rd_addr    <= '0;
      r_rd_pend       <= 1'b0;
      r_rd_tag        <= 1'b0;
      r_rsp_vld       <= '0;
    end else begin
      sram_wr_en <= w_wr_fire;
      if (w_wr_fire) begin
        sram_wr_addr    <= w_wr_win.addr;
        sram_wr_data    <= w_wr_win.data;
        sram_wr_byte_en <= w_wr_win.be;
      end
      r_rd_pend <= w_rd_fire;
      if (w_rd_fire) begin
        sram_rd_addr <= w_rd_addr_win;
        r_rd_tag     <= w_rd_grant[REQ_EVICT];
      end
      r_rsp_vld[0] <= r_rd_pend & ~r_rd_tag;
      r_rsp_vld[1] <= r_rd_pend & r_rd_tag;
    end
  end

`ifdef DCACHE_ARB_BYPASS_EN
  logic                  r_byp_hit;
  logic                  r_byp_hit2;
  logic [DATA_WIDTH-1:0] r_byp_data;
  logic [BE_WIDTH-1:0]   r_byp_be;

  // The colliding write sits on the SRAM write port one cycle later; capture it from there
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byp_hit  <= 1'b0;
      r_byp_hit2 <= 1'b0;
      r_byp_data <= '0;
      r_byp_be   <= '0;
    end else begin
      r_byp_hit  <= w_addr_eq & w_rd_fire;
      r_byp_hit2 <= r_byp_hit;
      r_byp_data <= sram_wr_data;
      r_byp_be   <= sram_wr_byte_en;
    end
  end

  always_comb begin
    w_rsp_data = sram_rd_data;
    if (r_byp_hit2) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (r_byp_be[b])
          w_rsp_data[8*b +: 8] = r_byp_data[8*b +: 8];
      end
    end
  end
`else
  assign w_rsp_data = sram_rd_data;
`endif

  assign r0_rvalid   = r_rsp_vld[0] & ~rst;
  assign r1_rvalid   = r_rsp_vld[1] & ~rst;
  assign rd_data_out = (r0_rvalid | r1_rvalid) ? w_rsp_data : '0;

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// Directed bench for dcache_sram_arbiter with a behavioural SRAM (read-before-write on collision).
module tb_dcache_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        w0_valid, w0_ready, w1_valid, w1_ready;
  logic [8:0]  w0_addr, w1_addr;
  logic [31:0] w0_data, w1_data;
  logic [3:0]  w0_be, w1_be;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [8:0]  r0_addr, r1_addr;
  logic        r0_rvalid, r1_rvalid;
  logic [31:0] rd_data_out;
  logic        sram_wr_en;
  logic [8:0]  sram_wr_addr, sram_rd_addr;
  logic [31:0] sram_wr_data;
  logic [3:0]  sram_wr_byte_en;
  logic [31:0] sram_rd_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mem [512] = '{default: 32'h0};

  always #5 clk = ~clk;

  dcache_sram_arbiter #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (32),
    .BE_WIDTH   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .w0_valid        (w0_valid),
    .w0_ready        (w0_ready),
    .w0_addr         (w0_addr),
    .w0_data         (w0_data),
    .w0_be           (w0_be),
    .w1_valid        (w1_valid),
    .w1_ready        (w1_ready),
    .w1_addr         (w1_addr),
    .w1_data         (w1_data),
    .w1_be           (w1_be),
    .r0_valid        (r0_valid),
    .r0_ready        (r0_ready),
    .r0_addr         (r0_addr),
    .r1_valid        (r1_valid),
    .r1_ready        (r1_ready),
    .r1_addr         (r1_addr),
    .r0_rvalid       (r0_rvalid),
    .r1_rvalid       (r1_rvalid),
    .rd_data_out     (rd_data_out),
    .sram_wr_en      (sram_wr_en),
    .sram_wr_addr    (sram_wr_addr),
    .sram_wr_data    (sram_wr_data),
    .sram_wr_byte_en (sram_wr_byte_en),
    .sram_rd_addr    (sram_rd_addr),
    .sram_rd_data    (sram_rd_data)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  always @(posedge clk) begin
    if (sram_wr_en) mem[sram_wr_addr] <= merge(mem[sram_wr_addr], sram_wr_data, sram_wr_byte_en);
    sram_rd_data <= mem[sram_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_valids();
    w0_valid = 1'b0; w1_valid = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_valids();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input int unsigned port, input logic [8:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    if (port == 0) begin
      w0_valid = 1'b1; w0_addr = a; w0_data = d; w0_be = be;
    end else begin
      w1_valid = 1'b1; w1_addr = a; w1_data = d; w1_be = be;
    end
    #1;
    check("wr_ready", (port == 0) ? w0_ready : w1_ready, 32'd1);
    step();
    w0_valid = 1'b0; w1_valid = 1'b0;
  endtask

  task automatic rd(input int unsigned port, input logic [8:0] a, input logic [31:0] exp);
    if (port == 0) begin
      r0_valid = 1'b1; r0_addr = a;
    end else begin
      r1_valid = 1'b1; r1_addr = a;
    end
    #1;
    check("rd_ready", (port == 0) ? r0_ready : r1_ready, 32'd1);
    step();
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();
    check("rd_rvalid_own", (port == 0) ? r0_rvalid : r1_rvalid, 32'd1);
    check("rd_rvalid_other", (port == 0) ? r1_rvalid : r0_rvalid, 32'd0);
    check("rd_data", rd_data_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_valids();
    w0_addr = '0; w0_data = '0; w0_be = '0;
    w1_addr = '0; w1_data = '0; w1_be = '0;
    r0_addr = '0; r1_addr = '0;

    // Reset: ready stays low even with all requesters valid
    step();
    w0_valid = 1'b1; w1_valid = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    check("rst_w0_ready", w0_ready, 32'd0);
    check("rst_w1_ready", w1_ready, 32'd0);
    check("rst_r0_ready", r0_ready, 32'd0);
    check("rst_r1_ready", r1_ready, 32'd0);
    step();
    check("rst_wr_en", sram_wr_en, 32'd0);
    check("rst_wr_addr", sram_wr_addr, 32'd0);
    check("rst_wr_data", sram_wr_data, 32'd0);
    check("rst_wr_be", sram_wr_byte_en, 32'd0);
    check("rst_rd_addr", sram_rd_addr, 32'd0);
    check("rst_r0_rvalid", r0_rvalid, 32'd0);
    check("rst_r1_rvalid", r1_rvalid, 32'd0);
    check("rst_rd_data", rd_data_out, 32'd0);
    clear_valids();
    rst = 1'b0;

    // Basic write then read two cycles later
    w0_valid = 1'b1; w0_addr = 9'h005; w0_data = 32'hDEADBEEF; w0_be = 4'hF;
    #1;
    check("t1_w0_ready", w0_ready, 32'd1);
    step();
    w0_valid = 1'b0;
    check("t1_wr_en", sram_wr_en, 32'd1);
    check("t1_wr_addr", sram_wr_addr, 32'h005);
    check("t1_wr_data", sram_wr_data, 32'hDEADBEEF);
    check("t1_wr_be", sram_wr_byte_en, 32'hF);
    step();
    check("t1_wr_en_off", sram_wr_en, 32'd0);
    r0_valid = 1'b1; r0_addr = 9'h005;
    #1;
    check("t1_r0_ready", r0_ready, 32'd1);
    step();
    r0_valid = 1'b0;
    check("t1_rd_addr", sram_rd_addr, 32'h005);
    check("t1_rvalid_early", r0_rvalid, 32'd0);
    step();
    check("t1_r0_rvalid", r0_rvalid, 32'd1);
    check("t1_r1_rvalid", r1_rvalid, 32'd0);
    check("t1_rd_data", rd_data_out, 32'hDEADBEEF);
    step();
    check("t1_rvalid_after", r0_rvalid, 32'd0);

    // Write round-robin from a fresh pointer: w0,w1,w0,w1
    do_reset();
    w0_valid = 1'b1; w0_addr = 9'h010; w0_data = 32'hA0A0A0A0; w0_be = 4'hF;
    w1_valid = 1'b1; w1_addr = 9'h011; w1_data = 32'hB1B1B1B1; w1_be = 4'hF;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      check("rr_w0_ready", w0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_w1_ready", w1_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) begin
        check("rr_wr_en", sram_wr_en, 32'd1);
        check("rr_wr_addr", sram_wr_addr, ((i - 1) % 2 == 0) ? 32'h010 : 32'h011);
      end
      step();
    end
    clear_valids();
    check("rr_wr_en_last", sram_wr_en, 32'd1);
    check("rr_wr_addr_last", sram_wr_addr, 32'h011);
    step();
    check("rr_wr_en_off", sram_wr_en, 32'd0);
    rd(0, 9'h010, 32'hA0A0A0A0);
    rd(1, 9'h011, 32'hB1B1B1B1);

    // Byte enables merge into existing word
    wr(0, 9'h020, 32'h11223344, 4'hF);
    wr(1, 9'h020, 32'hAABBCCDD, 4'b0101);
    rd(0, 9'h020, 32'h11BB33DD);

    // Same-cycle write/read collision at the top address
    w0_valid = 1'b1; w0_addr = 9'h1FF; w0_data = 32'hCAFEF00D; w0_be = 4'hF;
    r0_valid = 1'b1; r0_addr = 9'h1FF;
    #1;
    check("col_w0_ready", w0_ready, 32'd1);
`ifdef DCACHE_ARB_BYPASS_EN
    check("col_r0_ready", r0_ready, 32'd1);
    step();
    clear_valids();
    step();
`else
    check("col_r0_ready_blocked", r0_ready, 32'd0);
    step();
    w0_valid = 1'b0;
    #1;
    check("col_r0_ready_retry", r0_ready, 32'd1);
    step();
    r0_valid = 1'b0;
    step();
`endif
    check("col_r0_rvalid", r0_rvalid, 32'd1);
    check("col_rd_data", rd_data_out, 32'hCAFEF00D);
    step();

    // Alternating readers at both address ends
    do_reset();
    wr(0, 9'h000, 32'h0BADF00D, 4'hF);
    r0_valid = 1'b1; r0_addr = 9'h000;
    r1_valid = 1'b1; r1_addr = 9'h1FF;
    for (int unsigned i = 0; i < 10; i++) begin
      if (i == 8) clear_valids();
      #1;
      if (i < 8) begin
        check("alt_r0_ready", r0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
        check("alt_r1_ready", r1_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (i >= 2) begin
        check("alt_r0_rvalid", r0_rvalid, ((i - 2) % 2 == 0) ? 32'd1 : 32'd0);
        check("alt_r1_rvalid", r1_rvalid, ((i - 2) % 2 == 1) ? 32'd1 : 32'd0);
        check("alt_rd_data", rd_data_out, ((i - 2) % 2 == 0) ? 32'h0BADF00D : 32'hCAFEF00D);
      end
      step();
    end

    // Reset in the cycle after a read accept drops the read
    r0_valid = 1'b1; r0_addr = 9'h005;
    #1;
    check("mid_r0_ready", r0_ready, 32'd1);
    step();
    r0_valid = 1'b0;
    rst = 1'b1;
    w0_valid = 1'b1; w0_addr = 9'h033;
    #1;
    check("mid_w0_ready_rst", w0_ready, 32'd0);
    step();
    rst = 1'b0;
    w0_valid = 1'b0;
    check("mid_r0_rvalid", r0_rvalid, 32'd0);
    check("mid_rd_data", rd_data_out, 32'd0);
    check("mid_rd_addr", sram_rd_addr, 32'd0);
    check("mid_wr_en", sram_wr_en, 32'd0);
    check("mid_wr_data", sram_wr_data, 32'd0);
    step();
    check("mid_r0_rvalid_late", r0_rvalid, 32'd0);
    check("mid_r1_rvalid_late", r1_rvalid, 32'd0);

    // Response due in the reset cycle is suppressed
    r1_valid = 1'b1; r1_addr = 9'h1FF;
    #1;
    check("sup_r1_ready", r1_ready, 32'd1);
    step();
    r1_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("sup_r1_rvalid", r1_rvalid, 32'd0);
    check("sup_rd_data", rd_data_out, 32'd0);
    step();
    rst = 1'b0;
    check("sup_r1_rvalid_after", r1_rvalid, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
